// File: rtl/lcd_byte_transfer_if.sv
// Request/handshake bundle between the LCD command sequencer and the byte
// transfer engine.
interface lcd_byte_transfer_if #(
  parameter int DELAY_W = 21
);
  logic               send;
  logic [7:0]         data;
  logic               rs;
  logic               nibble_only;
  logic               use_bf;
  logic [DELAY_W-1:0] delay;
  logic               ready;
  logic               done;
  logic               bf_timeout;

  modport master (
    output send, data, rs, nibble_only, use_bf, delay,
    input  ready, done, bf_timeout
  );

  modport slave (
    input  send, data, rs, nibble_only, use_bf, delay,
    output ready, done, bf_timeout
  );
endinterface

// File: rtl/lcd_byte_transfer.sv
// lcd_byte_transfer: serialises one HD44780 command/data byte onto a 4- or
// 8-bit LCD bus with setup/E-pulse/hold timing. Completion is either a fixed
// delay or busy-flag polling with a timeout. All pin outputs are registered.
module lcd_byte_transfer #(
  parameter int CLK_FREQ      = 50000000,
  parameter int BUS_WIDTH     = 4,
  parameter int SETUP_US      = 1,
  parameter int E_PULSE_US    = 3,
  parameter int HOLD_US       = 1,
  parameter int DELAY_W       = 21,
  parameter int BF_TIMEOUT_US = 10000
) (
  input  logic                 CLK,
  input  logic                 RST,
  lcd_byte_transfer_if.slave   bus,
  inout  wire  [BUS_WIDTH-1:0] LCD_D,
  output logic                 LCD_RW,
  output logic                 LCD_E,
  output logic                 LCD_RS
);

  localparam int T_US   = CLK_FREQ / 1000000;
  localparam int S_CYC  = T_US * SETUP_US;
  localparam int P_CYC  = T_US * E_PULSE_US;
  localparam int H_CYC  = T_US * HOLD_US;
  localparam int TO_CYC = T_US * BF_TIMEOUT_US;
  localparam int PH_MAX = (S_CYC > P_CYC) ? ((S_CYC > H_CYC) ? S_CYC : H_CYC)
                                          : ((P_CYC > H_CYC) ? P_CYC : H_CYC);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TW0    = (DELAY_W > 21) ? DELAY_W : 21;
  localparam int TW     = (PH_W > TW0) ? PH_W : TW0;
  localparam int PW     = $clog2(TO_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_E, W_HOLD, WAIT,
    R_SETUP, R_E, R_HOLD, R_E2, R_HOLD2, DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [TW-1:0]      r_timer;
  logic [TW-1:0]      w_len;
  logic               w_last;
  logic [7:0]         r_data;
  logic               r_rs_l, r_nib, r_use_bf, r_beat, r_bf;
  logic [DELAY_W-1:0] r_delay;
  logic [PW-1:0]      r_poll;
  logic               w_accept, w_to_evt, w_poll_end, w_beat_nxt;
  logic [7:0]         w_data_l;
  logic               w_rs_l;
  logic               w_e_nxt, w_rw_nxt, w_rs_nxt;
  logic [BUS_WIDTH-1:0] w_d_nxt;
  logic               r_e, r_rw, r_rs, r_drv, r_ready, r_done, r_bf_to;
  logic [BUS_WIDTH-1:0] r_d;

  // Length of the current phase and end-of-phase detect.
  always_comb begin
    w_len = '0;
    case (r_state)
      W_SETUP, R_SETUP:       w_len = TW'(S_CYC);
      W_E, R_E, R_E2:         w_len = TW'(P_CYC);
      W_HOLD, R_HOLD, R_HOLD2: w_len = TW'(H_CYC);
      WAIT:                   w_len = TW'(r_delay);
      default:                w_len = '0;
    endcase
    w_last = (r_timer == (w_len - TW'(1)));
  end

  // Next-state logic and registered-output decode of the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_accept    = 1'b0;
    w_to_evt    = 1'b0;
    w_poll_end  = 1'b0;
    case (r_state)
      IDLE: if (bus.send) begin
        w_accept    = 1'b1;
        w_state_nxt = W_SETUP;
        w_beat_nxt  = 1'b0;
      end
      W_SETUP: if (w_last) w_state_nxt = W_E;
      W_E:     if (w_last) w_state_nxt = W_HOLD;
      W_HOLD: if (w_last) begin
        if (BUS_WIDTH == 4 && !r_nib && !r_beat) begin
          w_state_nxt = W_SETUP;
          w_beat_nxt  = 1'b1;
        end else if (r_use_bf) begin
          w_state_nxt = R_SETUP;
        end else if (r_delay == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT:    if (w_last) w_state_nxt = DONE;
      R_SETUP: if (w_last) w_state_nxt = R_E;
      R_E:     if (w_last) w_state_nxt = R_HOLD;
      R_HOLD: if (w_last) begin
        if (BUS_WIDTH == 4) w_state_nxt = R_E2;
        else                w_poll_end  = 1'b1;
      end
      R_E2:    if (w_last) w_state_nxt = R_HOLD2;
      R_HOLD2: if (w_last) w_poll_end = 1'b1;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // A poll cycle always runs to completion, so E is never cut short by the timeout.
    if (w_poll_end) begin
      if (!r_bf) begin
        w_state_nxt = DONE;
      end else if (r_poll >= PW'(TO_CYC - 1)) begin
        w_state_nxt = DONE;
        w_to_evt    = 1'b1;
      end else begin
        w_state_nxt = R_SETUP;
      end
    end

    // Pin values are decoded from the next state so the registers line up with it.
    w_data_l = w_accept ? bus.data : r_data;
    w_rs_l   = w_accept ? bus.rs   : r_rs_l;
    w_e_nxt  = w_state_nxt inside {W_E, R_E, R_E2};
    w_rw_nxt = w_state_nxt inside {R_SETUP, R_E, R_HOLD, R_E2, R_HOLD2};
    w_rs_nxt = 1'b0;
    w_d_nxt  = '0;
    if (w_state_nxt inside {W_SETUP, W_E, W_HOLD, WAIT}) begin
      w_rs_nxt = w_rs_l;
      if (BUS_WIDTH == 8) w_d_nxt = BUS_WIDTH'(w_data_l);
      else                w_d_nxt = BUS_WIDTH'(w_beat_nxt ? w_data_l[3:0] : w_data_l[7:4]);
    end
  end

  // State, phase timer, beat index, poll timer and busy-flag sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_beat  <= 1'b0;
      r_poll  <= '0;
      r_bf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      if (w_state_nxt != r_state || r_state == IDLE) r_timer <= '0;
      else                                          r_timer <= r_timer + TW'(1);
      if (r_state inside {R_SETUP, R_E, R_HOLD, R_E2, R_HOLD2}) begin
        if (r_poll != PW'(TO_CYC)) r_poll <= r_poll + PW'(1);
      end else begin
        r_poll <= '0;
      end
      if (r_state == R_E && w_last) r_bf <= LCD_D[BUS_WIDTH-1];
    end
  end

  // Request latch, captured once when a send is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data   <= '0;
      r_rs_l   <= 1'b0;
      r_nib    <= 1'b0;
      r_use_bf <= 1'b0;
      r_delay  <= '0;
    end else if (w_accept) begin
      r_data   <= bus.data;
      r_rs_l   <= bus.rs;
      r_nib    <= bus.nibble_only;
      r_use_bf <= bus.use_bf;
      r_delay  <= bus.delay;
    end
  end

  // Registered pins and status; bus drive resumes only after RW was low a cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_e     <= 1'b0;
      r_rw    <= 1'b0;
      r_rs    <= 1'b0;
      r_d     <= '0;
      r_drv   <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_bf_to <= 1'b0;
    end else begin
      r_e     <= w_e_nxt;
      r_rw    <= w_rw_nxt;
      r_rs    <= w_rs_nxt;
      r_d     <= w_d_nxt;
      r_drv   <= !w_rw_nxt && !r_rw;
      r_ready <= (w_state_nxt == IDLE);
      r_done  <= (w_state_nxt == DONE);
      if (w_accept)      r_bf_to <= 1'b0;
      else if (w_to_evt) r_bf_to <= 1'b1;
    end
  end

  assign LCD_D          = r_drv ? r_d : {BUS_WIDTH{1'bz}};
  assign LCD_E          = r_e;
  assign LCD_RW         = r_rw;
  assign LCD_RS         = r_rs;
  assign bus.ready      = r_ready;
  assign bus.done       = r_done;
  assign bus.bf_timeout = r_bf_to;

endmodule

// File: tb/tb_lcd_byte_transfer.sv
// Directed bench for lcd_byte_transfer: a 4-bit instance (20 us BF timeout)
// and an 8-bit instance, each with a small busy-flag LCD model on its bus.
module tb_lcd_byte_transfer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_byte_transfer_if #(.DELAY_W(21)) if4 ();
  lcd_byte_transfer_if #(.DELAY_W(21)) if8 ();

  wire  [3:0] lcd_d4;
  wire  [7:0] lcd_d8;
  logic       e4, rw4, rs4, e8, rw8, rs8;

  lcd_byte_transfer #(.CLK_FREQ(50000000), .BUS_WIDTH(4), .SETUP_US(1), .E_PULSE_US(3),
                      .HOLD_US(1), .DELAY_W(21), .BF_TIMEOUT_US(20)) dut4 (
    .CLK(clk), .RST(rst), .bus(if4), .LCD_D(lcd_d4), .LCD_RW(rw4), .LCD_E(e4), .LCD_RS(rs4));

  lcd_byte_transfer #(.CLK_FREQ(50000000), .BUS_WIDTH(8), .SETUP_US(1), .E_PULSE_US(3),
                      .HOLD_US(1), .DELAY_W(21), .BF_TIMEOUT_US(10000)) dut8 (
    .CLK(clk), .RST(rst), .bus(if8), .LCD_D(lcd_d8), .LCD_RW(rw8), .LCD_E(e8), .LCD_RS(rs8));

  // LCD models: drive only while RW=1, busy flag on the MSB, other bits 0.
  logic m4_busy = 1'b0;
  int   m8_rp = 0, m8_base = 0, m8_busy = 0;
  logic m8_bf;
  assign m8_bf  = ((m8_rp - m8_base) < m8_busy);
  assign lcd_d4 = rw4 ? {m4_busy, 3'b000} : 4'bzzzz;
  assign lcd_d8 = rw8 ? {m8_bf, 7'b0000000} : 8'bzzzzzzzz;
  always @(negedge e8) if (rw8) m8_rp <= m8_rp + 1;

  int errors = 0;
  int checks = 0;

  int         m_rise[$], m_fall[$];
  logic [7:0] m_wd[$];
  logic       m_wrs[$];
  int m_nr, m_done_t, m_done_cnt, m_rd_bad, m_ready_bad;
  logic m_ready_after, m_bfto_done, m_bfto_1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start(input bit w8, input logic [7:0] dat, input bit rs, input bit nib,
                       input bit ubf, input int dly);
    @(negedge clk);
    if (w8) begin
      if8.data = dat; if8.rs = rs; if8.nibble_only = nib; if8.use_bf = ubf;
      if8.delay = 21'(dly); if8.send = 1'b1;
    end else begin
      if4.data = dat; if4.rs = rs; if4.nibble_only = nib; if4.use_bf = ubf;
      if4.delay = 21'(dly); if4.send = 1'b1;
    end
    @(posedge clk);
    #1;
    // scramble inputs after the accept edge; the engine must ignore them
    if (w8) begin
      if8.send = 1'b0; if8.data = ~dat; if8.rs = ~rs; if8.nibble_only = ~nib;
      if8.use_bf = ~ubf; if8.delay = 21'(dly + 7);
    end else begin
      if4.send = 1'b0; if4.data = ~dat; if4.rs = ~rs; if4.nibble_only = ~nib;
      if4.use_bf = ~ubf; if4.delay = 21'(dly + 7);
    end
  endtask

  // Samples each negedge after an accept; sample i reflects the state after edge accept+(i-1).
  task automatic observe(input bit w8, input int budget, input bit spam, input int extra);
    bit pe, e, rw, rs, dn, rdy, bto;
    logic [7:0] d;
    m_rise.delete(); m_fall.delete(); m_wd.delete(); m_wrs.delete();
    m_nr = 0; m_done_t = -1; m_done_cnt = 0; m_rd_bad = 0; m_ready_bad = 0;
    m_ready_after = 1'b0; m_bfto_done = 1'b0; m_bfto_1 = 1'b1;
    pe = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      e   = w8 ? e8 : e4;
      rw  = w8 ? rw8 : rw4;
      rs  = w8 ? rs8 : rs4;
      dn  = w8 ? if8.done : if4.done;
      rdy = w8 ? if8.ready : if4.ready;
      bto = w8 ? if8.bf_timeout : if4.bf_timeout;
      d   = w8 ? lcd_d8 : {4'b0000, lcd_d4};
      if (i == 1) m_bfto_1 = bto;
      if (e && !pe) begin
        m_rise.push_back(i);
        if (rw) m_nr++;
        else begin m_wd.push_back(d); m_wrs.push_back(rs); end
      end
      if (!e && pe) m_fall.push_back(i);
      pe = e;
      if (rw && ((d & (w8 ? 8'h7F : 8'h07)) != 8'h00)) m_rd_bad++;
      if (rw && rs) m_rd_bad++;
      if (m_done_t < 0 && rdy) m_ready_bad++;
      if (spam && m_done_t < 0 && !dn) begin
        if (w8) if8.send = 1'b1; else if4.send = 1'b1;
      end
      if (dn) begin
        m_done_cnt++;
        if (m_done_t < 0) begin
          m_done_t = i;
          m_bfto_done = bto;
          if (w8) if8.send = 1'b0; else if4.send = 1'b0;
        end
      end
      if (m_done_t > 0 && i == m_done_t + 1) m_ready_after = rdy;
      if (m_done_t > 0 && i >= m_done_t + extra) break;
    end
  endtask

  task automatic test_reset();
    if4.send = 0; if4.data = 0; if4.rs = 0; if4.nibble_only = 0; if4.use_bf = 0; if4.delay = 0;
    if8.send = 0; if8.data = 0; if8.rs = 0; if8.nibble_only = 0; if8.use_bf = 0; if8.delay = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({e4, rs4, rw4} !== 3'b000) begin errors++; $display("FAIL reset_pins4: got E/RS/RW=%b want 000", {e4, rs4, rw4}); end
    checks++; if (lcd_d4 !== 4'h0) begin errors++; $display("FAIL reset_d4: got %h want 0", lcd_d4); end
    checks++; if ({if4.ready, if4.done, if4.bf_timeout} !== 3'b100) begin errors++; $display("FAIL reset_status4: got ready/done/bfto=%b want 100", {if4.ready, if4.done, if4.bf_timeout}); end
    checks++; if ({e8, rs8, rw8} !== 3'b000) begin errors++; $display("FAIL reset_pins8: got E/RS/RW=%b want 000", {e8, rs8, rw8}); end
    checks++; if ({if8.ready, if8.done, if8.bf_timeout} !== 3'b100) begin errors++; $display("FAIL reset_status8: got ready/done/bfto=%b want 100", {if8.ready, if8.done, if8.bf_timeout}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write4();
    int bad;
    start(1'b0, 8'h28, 1'b0, 1'b0, 1'b0, 2000);
    observe(1'b0, 4000, 1'b0, 1);
    checks++; if (m_done_t < 0) begin errors++; $display("FAIL write4_done_seen: got no done want done within 4000 cycles"); end
    checks++; if (m_wd.size() !== 2 || m_fall.size() !== 2) begin errors++; $display("FAIL write4_pulses: got %0d/%0d want 2 write pulses", m_wd.size(), m_fall.size()); end
    if (m_wd.size() == 2 && m_fall.size() == 2) begin
      checks++; if (m_wd[0] !== 8'h02 || m_wd[1] !== 8'h08) begin errors++; $display("FAIL write4_nibbles: got %h,%h want 02,08", m_wd[0], m_wd[1]); end
      checks++; if (m_wrs[0] !== 1'b0 || m_wrs[1] !== 1'b0) begin errors++; $display("FAIL write4_rs: got %b%b want 00", m_wrs[0], m_wrs[1]); end
      checks++; if (m_rise[0] - 1 !== 50) begin errors++; $display("FAIL write4_setup: got %0d want 50", m_rise[0] - 1); end
      bad = 0;
      for (int j = 0; j < 2; j++) if (m_fall[j] - m_rise[j] != 150) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL write4_e_width: got %0d wrong pulses want 0 (first=%0d)", bad, m_fall[0] - m_rise[0]); end
      checks++; if (m_rise[1] - m_fall[0] !== 100) begin errors++; $display("FAIL write4_hold_setup_gap: got %0d want 100", m_rise[1] - m_fall[0]); end
    end
    checks++; if (m_done_t - 1 < 2500 || m_done_t - 1 > 2501) begin errors++; $display("FAIL write4_done_time: got %0d want 2500", m_done_t - 1); end
    checks++; if (m_ready_after !== 1'b1) begin errors++; $display("FAIL write4_ready_after: got %b want 1", m_ready_after); end
    checks++; if (m_ready_bad !== 0) begin errors++; $display("FAIL write4_ready_busy: got %0d ready-high samples want 0", m_ready_bad); end
    checks++; if (m_nr !== 0) begin errors++; $display("FAIL write4_no_reads: got %0d want 0", m_nr); end
  endtask

  task automatic test_nibble();
    start(1'b0, 8'h30, 1'b0, 1'b1, 1'b0, 100);
    observe(1'b0, 1000, 1'b0, 1);
    checks++; if (m_wd.size() !== 1) begin errors++; $display("FAIL nibble_pulses: got %0d want 1", m_wd.size()); end
    if (m_wd.size() == 1 && m_fall.size() == 1) begin
      checks++; if (m_wd[0] !== 8'h03 || m_wrs[0] !== 1'b0) begin errors++; $display("FAIL nibble_value: got d=%h rs=%b want 03/0", m_wd[0], m_wrs[0]); end
      checks++; if (m_fall[0] - m_rise[0] !== 150) begin errors++; $display("FAIL nibble_e_width: got %0d want 150", m_fall[0] - m_rise[0]); end
    end
    checks++; if (m_done_t - 1 !== 350) begin errors++; $display("FAIL nibble_done_time: got %0d want 350", m_done_t - 1); end
  endtask

  task automatic test_bf8();
    int bad;
    m8_base = m8_rp;
    m8_busy = 3;
    start(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 0);
    observe(1'b1, 3000, 1'b0, 1);
    checks++; if (m_wd.size() !== 1) begin errors++; $display("FAIL bf8_writes: got %0d want 1", m_wd.size()); end
    if (m_wd.size() == 1) begin
      checks++; if (m_wd[0] !== 8'hA5 || m_wrs[0] !== 1'b1) begin errors++; $display("FAIL bf8_write_value: got d=%h rs=%b want a5/1", m_wd[0], m_wrs[0]); end
    end
    checks++; if (m_nr !== 4) begin errors++; $display("FAIL bf8_reads: got %0d want 4", m_nr); end
    bad = 0;
    for (int j = 0; j < m_fall.size(); j++) if (m_fall[j] - m_rise[j] != 150) bad++;
    checks++; if (bad !== 0 || m_fall.size() !== 5) begin errors++; $display("FAIL bf8_e_width: got %0d bad of %0d want 0 of 5", bad, m_fall.size()); end
    checks++; if (m_rd_bad !== 0) begin errors++; $display("FAIL bf8_read_bus: got %0d bad samples want 0", m_rd_bad); end
    checks++; if (m_done_t - 1 !== 1250) begin errors++; $display("FAIL bf8_done_time: got %0d want 1250", m_done_t - 1); end
    checks++; if (m_bfto_done !== 1'b0) begin errors++; $display("FAIL bf8_timeout_flag: got %b want 0", m_bfto_done); end
    m8_busy = 0;
  endtask

  task automatic test_timeout4();
    int bad;
    m4_busy = 1'b1;
    start(1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 0);
    observe(1'b0, 3000, 1'b0, 1);
    checks++; if (m_done_t < 0) begin errors++; $display("FAIL to4_done_seen: got no done want done within 3000 cycles"); end
    checks++; if (m_bfto_done !== 1'b1) begin errors++; $display("FAIL to4_flag: got %b want 1", m_bfto_done); end
    checks++; if (m_done_t - 1 - 500 < 1000 || m_done_t - 1 - 500 > 1450) begin errors++; $display("FAIL to4_poll_time: got %0d want 1000..1450", m_done_t - 1 - 500); end
    bad = 0;
    for (int j = 0; j < m_fall.size(); j++) if (m_fall[j] - m_rise[j] != 150) bad++;
    checks++; if (bad !== 0 || m_fall.size() !== m_rise.size()) begin errors++; $display("FAIL to4_e_width: got %0d bad pulses want 0", bad); end
    checks++; if (m_nr < 2 || (m_nr % 2) != 0) begin errors++; $display("FAIL to4_read_pairs: got %0d want even >=2", m_nr); end
    m4_busy = 1'b0;
    @(negedge clk);
    checks++; if (if4.bf_timeout !== 1'b1) begin errors++; $display("FAIL to4_sticky: got %b want 1", if4.bf_timeout); end
    start(1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 5);
    observe(1'b0, 1000, 1'b0, 1);
    checks++; if (m_bfto_1 !== 1'b0) begin errors++; $display("FAIL to4_clear: got %b want 0", m_bfto_1); end
    checks++; if (m_done_t - 1 !== 255) begin errors++; $display("FAIL to4_next_done: got %0d want 255", m_done_t - 1); end
  endtask

  task automatic test_back_to_back();
    start(1'b0, 8'h41, 1'b1, 1'b0, 1'b0, 50);
    observe(1'b0, 2000, 1'b1, 400);
    checks++; if (m_rise.size() !== 2) begin errors++; $display("FAIL spam_pulses: got %0d want 2", m_rise.size()); end
    checks++; if (m_done_cnt !== 1) begin errors++; $display("FAIL spam_done_count: got %0d want 1", m_done_cnt); end
    if (m_wd.size() == 2) begin
      checks++; if (m_wd[0] !== 8'h04 || m_wd[1] !== 8'h01) begin errors++; $display("FAIL spam_nibbles: got %h,%h want 04,01", m_wd[0], m_wd[1]); end
    end
    checks++; if (m_done_t - 1 !== 550) begin errors++; $display("FAIL spam_done_time: got %0d want 550", m_done_t - 1); end
  endtask

  task automatic test_reset_mid();
    start(1'b0, 8'h28, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 300 && e4 !== 1'b1; i++) @(negedge clk);
    checks++; if (e4 !== 1'b1) begin errors++; $display("FAIL rstmid_e_seen: got %b want 1", e4); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({e4, rs4, rw4} !== 3'b000) begin errors++; $display("FAIL rstmid_pins: got E/RS/RW=%b want 000", {e4, rs4, rw4}); end
    checks++; if (lcd_d4 !== 4'h0) begin errors++; $display("FAIL rstmid_d: got %h want 0", lcd_d4); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (if4.ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", if4.ready); end
    start(1'b0, 8'h30, 1'b0, 1'b1, 1'b0, 10);
    observe(1'b0, 1000, 1'b0, 1);
    checks++; if (m_wd.size() !== 1 || m_done_t - 1 !== 260) begin errors++; $display("FAIL rstmid_next: got %0d pulses done=%0d want 1/260", m_wd.size(), m_done_t - 1); end
    if (m_wd.size() == 1) begin
      checks++; if (m_wd[0] !== 8'h03) begin errors++; $display("FAIL rstmid_next_data: got %h want 03", m_wd[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_write4();
    test_nibble();
    test_bf8();
    test_timeout4();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_byte_transfer.md
Name: lcd_byte_transfer

Overview:
Parametrised next-generation HD44780 bus transfer engine. It accepts a full byte command/data request and serialises it onto a 4-bit or 8-bit LCD bus with programmable setup/E-pulse/hold timing. Completion is detected either by a fixed cycle delay or by busy-flag polling (RW=1 read of DB7), with a timeout. It sits between the LCD init/command sequencer and the LCD pins.

Parameters:
CLK_FREQ, 50000000, clock frequency in Hz; base cycle count T_US = CLK_FREQ/1000000.
BUS_WIDTH, 4, LCD data bus width; legal values 4 or 8.
SETUP_US, 1, data/RS/RW setup time before E rises, in µs.
E_PULSE_US, 3, E high time, in µs.
HOLD_US, 1, hold time after E falls, in µs.
DELAY_W, 21, width of the fixed post-command delay count.
BF_TIMEOUT_US, 10000, maximum busy-flag polling time, in µs.

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous active-high reset
send  input  1  start request, sampled only in IDLE
data  input  8  byte to transfer
rs  input  1  register select for this transfer
nibble_only  input  1  4-bit mode only: send data[7:4] as a single nibble (init sequence)
use_bf  input  1  1 = poll busy flag after the write, 0 = wait delay cycles
delay  input  DELAY_W  post-write wait in cycles when use_bf=0
LCD_D  inout  BUS_WIDTH  LCD data bus; high-Z whenever LCD_RW=1
LCD_RW  output  1  LCD read/write select
LCD_E  output  1  LCD enable strobe
LCD_RS  output  1  LCD register select
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse on completion
bf_timeout  output  1  sticky error; set on BF timeout, cleared by the next accepted send

Behaviour:
- Phase lengths: S = T_US*SETUP_US, P = T_US*E_PULSE_US, H = T_US*HOLD_US cycles. Each phase lasts exactly that many cycles. A single 21-bit-minimum timer resets at every phase change.
- Reset (async): state IDLE; LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_D driven 0, done=0, bf_timeout=0, ready=1. Asserting reset mid-transfer aborts immediately; E drops asynchronously.
- IDLE: on send=1, latch data, rs, nibble_only, use_bf and delay. Clear bf_timeout and go to W_SETUP. Input changes after this latch have no effect. send is ignored outside IDLE; there is no queueing.
- Write beats:
  - 8-bit mode: one beat with data[7:0].
  - 4-bit mode: beat 0 = data[7:4], then beat 1 = data[3:0]. nibble_only=1 sends beat 0 only.
- Beat sequence: W_SETUP (S cycles; RW=0, RS=latched rs, D=beat value) -> W_E (P cycles, E=1) -> W_HOLD (H cycles, E=0, D still driven). Then either the next beat's W_SETUP, or completion.
- Completion with use_bf=0: WAIT for exactly `delay` cycles, then DONE. delay=0 means no WAIT cycles. After WAIT, RS=0 and D=0.
- Completion with use_bf=1:
  - R_SETUP (S cycles; RW=1, RS=0, bus released) -> R_E (P cycles, E=1). BF = LCD_D[BUS_WIDTH-1] sampled on the last cycle of R_E.
  - R_HOLD (H cycles).
  - In 4-bit mode a second read pulse (R_E2 P cycles, R_HOLD2 H cycles) fetches the low nibble, which is discarded.
  - If BF=1, repeat from R_SETUP. If BF=0, go to DONE with RW=0 and the bus driven 0 again.
  - Polling time counts from entry to the first R_SETUP. When it reaches T_US*BF_TIMEOUT_US, the current pulse is finished (E never truncated), bf_timeout is set, and the engine goes to DONE.
- DONE: done=1 for one cycle, then IDLE. ready=0 from the cycle after send is accepted until IDLE is re-entered.
- Bus turnaround: LCD_D is released in the same cycle RW goes high. The bus is driven again only after RW has been low for ≥1 cycle, so it is never driven while RW=1.
- Outputs LCD_E/LCD_RS/LCD_RW/LCD_D are registered; there are no combinational paths from inputs to pins.

Test Plan:
- BUS_WIDTH=4, CLK_FREQ=50 MHz, send data=0x28 rs=0 use_bf=0 delay=2000 -> LCD_D=0x2 then 0x8. Each E pulse is exactly 150 cycles with 50 setup/50 hold. done pulses 500+2000 cycles after the accept edge (+1). ready returns high the next cycle.
- nibble_only=1, data=0x30 -> a single E pulse with LCD_D=0x3, RS=0. done comes 250+delay cycles after accept.
- BUS_WIDTH=8, data=0xA5 rs=1 use_bf=1. Model holds DB7=1 for 3 polls then 0 -> one 150-cycle write pulse, then 4 read pulses with RW=1 and LCD_D high-Z throughout. done follows, and bf_timeout=0.
- BUS_WIDTH=4, use_bf=1, model holds DB7=1 forever, BF_TIMEOUT_US=20 -> bf_timeout set and done pulses at or after 1000 polling cycles. E is not truncated. The next send clears bf_timeout.
- Pulse send every cycle during an active transfer -> no extra transfers; exactly one done per accepted send.
- Assert RST while E=1 mid-transfer -> E, RS, RW and D go 0 asynchronously. After release, ready=1 and the next send runs a normal transfer.
